stack_frame_ctrl: RTL and testbench

Call-frame sequencer for the SuperStack operand stack in the WebAssembly core. It accepts CALL/RETURN commands from the instruction decoder and turns each into a short sequence of SuperStack operations: zero-filling locals, trimming the frame on return and carrying the result value across. It also drives the stack's underflow_limit, so each function only sees its own frame. It keeps an internal frame store of saved limits and return addresses.

---
 rtl/stack_frame_ctrl_if.sv | 61 ++++++
 rtl/stack_frame_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_stack_frame_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_frame_ctrl_if.sv
// SuperStack op/status codes and the decoder-facing command bus
// of the call-frame sequencer.
package superstack_pkg;
  localparam logic [2:0] OP_NONE                 = 3'd0;
  localparam logic [2:0] OP_PUSH                 = 3'd1;
  localparam logic [2:0] OP_POP                  = 3'd2;
  localparam logic [2:0] OP_REPLACE              = 3'd3;
  localparam logic [2:0] OP_INDEX_RESET          = 3'd4;
  localparam logic [2:0] OP_INDEX_RESET_AND_PUSH = 3'd5;

  localparam logic [2:0] ST_NONE      = 3'd0;
  localparam logic [2:0] ST_EMPTY     = 3'd1;
  localparam logic [2:0] ST_FULL      = 3'd2;
  localparam logic [2:0] ST_OVERFLOW  = 3'd3;
  localparam logic [2:0] ST_UNDERFLOW = 3'd4;
endpackage

interface stack_frame_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 7
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_ret;
  logic [DEPTH:0]   cmd_args;
  logic [DEPTH:0]   cmd_locals;
  logic             cmd_results;
  logic [WIDTH-1:0] cmd_ret_addr;
  logic             done;
  logic             err;
  logic [2:0]       err_code;
  logic [WIDTH-1:0] ret_addr;

  modport master (
    output cmd_valid,
    output cmd_ret,
    output cmd_args,
    output cmd_locals,
    output cmd_results,
    output cmd_ret_addr,
    input  cmd_ready,
    input  done,
    input  err,
    input  err_code,
    input  ret_addr
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ret,
    input  cmd_args,
    input  cmd_locals,
    input  cmd_results,
    input  cmd_ret_addr,
    output cmd_ready,
    output done,
    output err,
    output err_code,
    output ret_addr
  );
endinterface

// File: rtl/stack_frame_ctrl.sv
// Call-frame sequencer: turns CALL/RETURN into SuperStack ops
// and owns the stack's underflow_limit plus a LIFO of saved frames.
module stack_frame_ctrl
  import superstack_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 7,
  parameter int FRAMES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  stack_frame_ctrl_if.slave        cmd,
  output logic [$clog2(FRAMES):0]  frame_depth,
  output logic [2:0]               stk_op,
  output logic [WIDTH-1:0]         stk_data,
  output logic [DEPTH:0]           stk_offset,
  output logic [DEPTH:0]           stk_underflow_limit,
  input  logic [DEPTH:0]           stk_index,
  input  logic [WIDTH-1:0]         stk_out,
  input  logic [2:0]               stk_status
);

  localparam int AW = DEPTH + 1;
  localparam int FW = $clog2(FRAMES);
  localparam int DW = FW + 1;

  localparam logic [AW:0] MAX_STACK = {1'b0, {AW{1'b1}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_FULL    = 3'd1;
  localparam logic [2:0] E_NOFRAME = 3'd2;
  localparam logic [2:0] E_ARGS    = 3'd3;
  localparam logic [2:0] E_OVF     = 3'd4;
  localparam logic [2:0] E_STATUS  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       code_q, code_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    off_q, off_d;
  logic [AW-1:0]    lim_q, lim_d;
  logic [AW-1:0]    saved_q, saved_d;

  logic [AW-1:0]    fs_lim [FRAMES];
  logic [WIDTH-1:0] fs_ra  [FRAMES];

  logic             accept;
  logic             push;
  logic [FW-1:0]    top;
  logic [AW-1:0]    span;
  logic [AW:0]      sum;
  logic             frames_full;
  logic             no_frame;
  logic             args_bad;
  logic             ovf_bad;
  logic             res_bad;
  logic             stat_bad;

  assign accept      = cmd.cmd_valid & ready_q;
  assign top         = FW'(depth_q - DW'(1));
  assign span        = stk_index - lim_q;
  assign sum         = {1'b0, stk_index} + {1'b0, cmd.cmd_locals};
  assign frames_full = (depth_q == DW'(FRAMES));
  assign no_frame    = (depth_q == '0);
  assign args_bad    = (span < cmd.cmd_args);
  assign ovf_bad     = (sum > MAX_STACK);
  assign res_bad     = cmd.cmd_results & (stk_index <= lim_q);
  assign stat_bad    = (stk_status == ST_OVERFLOW) |
                       (stk_status == ST_UNDERFLOW);

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    err_d   = err_q;
    code_d  = code_q;
    ra_d    = ra_q;
    depth_d = depth_q;
    op_d    = OP_NONE;
    data_d  = data_q;
    off_d   = off_q;
    lim_d   = lim_q;
    saved_d = saved_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          code_d  = E_NONE;
          if (!cmd.cmd_ret) begin
            if (frames_full) begin
              code_d = E_FULL;
            end else if (args_bad) begin
              code_d = E_ARGS;
            end else if (ovf_bad) begin
              code_d = E_OVF;
            end
            if (frames_full | args_bad | ovf_bad) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              state_d = S_RESP;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
              op_d    = OP_INDEX_RESET;
              off_d   = sum[AW-1:0];
              data_d  = '0;
              lim_d   = stk_index - cmd.cmd_args;
              state_d = S_ISSUE;
            end
          end else begin
            if (no_frame | res_bad) begin
              err_d   = 1'b1;
              code_d  = no_frame ? E_NOFRAME : E_ARGS;
              done_d  = 1'b1;
              state_d = S_RESP;
            end else begin
              depth_d = depth_q - DW'(1);
              ra_d    = fs_ra[top];
              if (cmd.cmd_results) begin
                saved_d = fs_lim[top];
                state_d = S_FETCH;
              end else begin
                op_d    = OP_INDEX_RESET;
                off_d   = lim_q;
                lim_d   = fs_lim[top];
                state_d = S_ISSUE;
              end
            end
          end
        end
      end
      // stk_out holds the callee's top word during FETCH
      S_FETCH: begin
        op_d    = OP_INDEX_RESET_AND_PUSH;
        off_d   = lim_q;
        data_d  = stk_out;
        lim_d   = saved_q;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (stat_bad) begin
          err_d  = 1'b1;
          code_d = E_STATUS;
        end
        done_d  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= E_NONE;
      ra_q    <= '0;
      depth_q <= '0;
      op_q    <= OP_NONE;
      data_q  <= '0;
      off_q   <= '0;
      lim_q   <= '0;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ra_q    <= ra_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      data_q  <= data_d;
      off_q   <= off_d;
      lim_q   <= lim_d;
      saved_q <= saved_d;
    end
  end

  // Frame contents are only read below frame_depth, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fs_lim[depth_q[FW-1:0]] <= lim_q;
      fs_ra[depth_q[FW-1:0]]  <= cmd.cmd_ret_addr;
    end
  end

  assign cmd.cmd_ready        = ready_q;
  assign cmd.done             = done_q;
  assign cmd.err              = err_q;
  assign cmd.err_code         = code_q;
  assign cmd.ret_addr         = ra_q;
  assign frame_depth          = depth_q;
  assign stk_op               = op_q;
  assign stk_data             = data_q;
  assign stk_offset           = off_q;
  assign stk_underflow_limit  = lim_q;

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Bench for stack_frame_ctrl with a small SuperStack model,
// a vector table and a done-driven scoreboard.
`timescale 1ns/1ps
module tb_stack_frame_ctrl;
  import superstack_pkg::*;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 7;
  localparam int FRAMES = 16;
  localparam int AW     = DEPTH + 1;
  localparam int DW     = $clog2(FRAMES) + 1;
  localparam int NW     = 2 ** AW;
  localparam logic [AW-1:0] MAXI = '1;

  typedef struct {
    string            nm;
    logic             ret;
    logic [AW-1:0]    args;
    logic [AW-1:0]    locals;
    logic             res;
    logic [WIDTH-1:0] ra;
    logic             set_idx;
    logic [AW-1:0]    pre_idx;
    logic             frc;
    logic             err;
    logic [2:0]       code;
    logic [WIDTH-1:0] exp_ra;
    int               lat;
    logic [AW-1:0]    exp_idx;
    logic [AW-1:0]    exp_lim;
    logic [DW-1:0]    exp_depth;
    logic             chk_st;
    logic [2:0]       exp_st;
    int               probe;
    logic [2:0]       p_op;
    logic [AW-1:0]    p_off;
    logic [WIDTH-1:0] p_data;
    logic [AW-1:0]    p_lim;
  } vec_t;

  typedef struct {
    logic             err;
    logic [2:0]       code;
    logic [WIDTH-1:0] ra;
    logic             chk_ra;
    int               lat;
    int               ops;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_frame_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) cif ();

  logic [DW-1:0]    frame_depth;
  logic [2:0]       stk_op;
  logic [WIDTH-1:0] stk_data;
  logic [AW-1:0]    stk_offset;
  logic [AW-1:0]    stk_underflow_limit;
  logic [AW-1:0]    stk_index;
  logic [WIDTH-1:0] stk_out;
  logic [2:0]       stk_status;

  stack_frame_ctrl #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd                 (cif),
    .frame_depth         (frame_depth),
    .stk_op              (stk_op),
    .stk_data            (stk_data),
    .stk_offset          (stk_offset),
    .stk_underflow_limit (stk_underflow_limit),
    .stk_index           (stk_index),
    .stk_out             (stk_out),
    .stk_status          (stk_status)
  );

  // SuperStack model
  logic [WIDTH-1:0] mem [NW];
  logic [AW-1:0]    m_idx;
  logic [2:0]       m_st;
  logic             st_force;
  logic [1:0]       h_op;
  logic [WIDTH-1:0] h_val;

  function automatic logic [2:0] st_of(input logic [AW-1:0] i);
    if (i == MAXI) return ST_FULL;
    if (i == '0) return ST_EMPTY;
    return ST_NONE;
  endfunction

  always @(posedge clk) begin
    if (stk_op == OP_INDEX_RESET) begin
      for (int i = 0; i < NW; i++)
        if (i >= int'(m_idx) && i < int'(stk_offset)) mem[i] <= '0;
      m_idx <= stk_offset;
      m_st  <= st_of(stk_offset);
    end else if (stk_op == OP_INDEX_RESET_AND_PUSH) begin
      mem[stk_offset] <= stk_data;
      if (stk_offset == MAXI) begin
        m_st <= ST_OVERFLOW;
      end else begin
        m_idx <= stk_offset + AW'(1);
        m_st  <= st_of(stk_offset + AW'(1));
      end
    end else if (h_op == 2'd1) begin
      m_idx <= h_val[AW-1:0];
      m_st  <= st_of(h_val[AW-1:0]);
    end else if (h_op == 2'd2) begin
      mem[m_idx] <= h_val;
      m_idx      <= m_idx + AW'(1);
      m_st       <= st_of(m_idx + AW'(1));
    end
  end

  assign stk_index  = m_idx;
  assign stk_out    = (m_idx == '0) ? '0 : mem[m_idx - AW'(1)];
  assign stk_status = st_force ? ST_UNDERFLOW : m_st;

  int   checks = 0;
  int   errors = 0;
  sb_t  sbq [$];
  vec_t vecs [$];

  task automatic chk(input string nm, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic h_do(input logic [1:0] op, input logic [WIDTH-1:0] v);
    @(posedge clk); #1;
    h_op  = op;
    h_val = v;
    @(posedge clk); #1;
    h_op  = 2'd0;
  endtask

  function automatic vec_t mk(
    input string nm, input logic ret, input int args, input int locals,
    input logic res, input logic [WIDTH-1:0] ra, input int pre,
    input logic err, input logic [2:0] code,
    input logic [WIDTH-1:0] exp_ra, input int lat,
    input int eidx, input int elim, input int edep);
    vec_t v;
    v.nm = nm;          v.ret = ret;
    v.args = AW'(args); v.locals = AW'(locals);
    v.res = res;        v.ra = ra;
    v.set_idx = (pre >= 0);
    v.pre_idx = AW'(pre);
    v.frc = 1'b0;
    v.err = err;        v.code = code;
    v.exp_ra = exp_ra;  v.lat = lat;
    v.exp_idx = AW'(eidx);
    v.exp_lim = AW'(elim);
    v.exp_depth = DW'(edep);
    v.chk_st = 1'b0;    v.exp_st = ST_NONE;
    v.probe = 0;        v.p_op = OP_NONE;
    v.p_off = '0;       v.p_data = '0;
    v.p_lim = '0;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v);
    sb_t e;
    int  n;
    int  ops;
    bit  seen;
    bit  busy_bad;
    if (v.set_idx) h_do(2'd1, WIDTH'(v.pre_idx));
    st_force = v.frc;
    @(posedge clk); #1;
    cif.cmd_valid    = 1'b1;
    cif.cmd_ret      = v.ret;
    cif.cmd_args     = v.args;
    cif.cmd_locals   = v.locals;
    cif.cmd_results  = v.res;
    cif.cmd_ret_addr = v.ra;
    e.err    = v.err;
    e.code   = v.code;
    e.ra     = v.exp_ra;
    e.chk_ra = v.ret & ~v.err;
    e.lat    = v.lat;
    e.ops    = (v.lat == 1) ? 0 : 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    n = 0; ops = 0; seen = 0; busy_bad = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (stk_op != OP_NONE) ops++;
      if (cif.cmd_ready !== 1'b0) busy_bad = 1;
      if (v.probe == n) begin
        chk({v.nm, ".op"}, 32'(stk_op), 32'(v.p_op));
        chk({v.nm, ".offset"}, 32'(stk_offset), 32'(v.p_off));
        chk({v.nm, ".data"}, stk_data, v.p_data);
        chk({v.nm, ".issue_limit"}, 32'(stk_underflow_limit),
            32'(v.p_lim));
      end
      if (cif.done === 1'b1) begin
        seen = 1;
        e = sbq.pop_front();
        chk({v.nm, ".latency"}, 32'(n), 32'(e.lat));
        chk({v.nm, ".err"}, 32'(cif.err), 32'(e.err));
        chk({v.nm, ".err_code"}, 32'(cif.err_code), 32'(e.code));
        if (e.chk_ra) chk({v.nm, ".ret_addr"}, cif.ret_addr, e.ra);
        chk({v.nm, ".ops"}, 32'(ops), 32'(e.ops));
        chk({v.nm, ".index"}, 32'(stk_index), 32'(v.exp_idx));
        chk({v.nm, ".limit"}, 32'(stk_underflow_limit),
            32'(v.exp_lim));
        chk({v.nm, ".depth"}, 32'(frame_depth), 32'(v.exp_depth));
        if (v.chk_st) chk({v.nm, ".status"}, 32'(stk_status),
                          32'(v.exp_st));
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s.done: got none expected pulse within 12", v.nm);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    chk({v.nm, ".ready_busy"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    chk({v.nm, ".done_pulse"}, 32'(cif.done), 32'd0);
    chk({v.nm, ".ready_after"}, 32'(cif.cmd_ready), 32'd1);
    st_force = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".ready"}, 32'(cif.cmd_ready), 32'd1);
    chk({nm, ".done"}, 32'(cif.done), 32'd0);
    chk({nm, ".err"}, 32'(cif.err), 32'd0);
    chk({nm, ".err_code"}, 32'(cif.err_code), 32'd0);
    chk({nm, ".ret_addr"}, cif.ret_addr, 32'd0);
    chk({nm, ".depth"}, 32'(frame_depth), 32'd0);
    chk({nm, ".op"}, 32'(stk_op), 32'(OP_NONE));
    chk({nm, ".data"}, stk_data, 32'd0);
    chk({nm, ".offset"}, 32'(stk_offset), 32'd0);
    chk({nm, ".limit"}, 32'(stk_underflow_limit), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset            = 1'b0;
    st_force         = 1'b0;
    h_op             = 2'd0;
    h_val            = '0;
    cif.cmd_valid    = 1'b0;
    cif.cmd_ret      = 1'b0;
    cif.cmd_args     = '0;
    cif.cmd_locals   = '0;
    cif.cmd_results  = 1'b0;
    cif.cmd_ret_addr = '0;

    vecs.push_back(mk("ret_empty", 1, 0, 0, 0, 0, -1,
                      1, 2, 0, 1, 2, 0, 0));
    vecs.push_back(mk("call_ovf", 0, 0, 6, 0, 32'h200, 250,
                      1, 4, 0, 1, 250, 0, 0));
    v = mk("call_full_ok", 0, 0, 5, 0, 32'h204, -1,
           0, 0, 0, 3, 255, 250, 1);
    v.chk_st = 1'b1;
    v.exp_st = ST_FULL;
    vecs.push_back(v);
    vecs.push_back(mk("ret_nores", 1, 0, 0, 0, 0, -1,
                      0, 0, 32'h204, 3, 250, 0, 0));
    vecs.push_back(mk("call_argunf", 0, 5, 0, 0, 32'h300, 3,
                      1, 3, 0, 1, 3, 0, 0));
    vecs.push_back(mk("call_zero", 0, 0, 0, 0, 32'h310, -1,
                      0, 0, 0, 3, 3, 3, 1));
    vecs.push_back(mk("ret_res_unf", 1, 0, 0, 1, 0, -1,
                      1, 3, 0, 1, 3, 3, 1));
    vecs.push_back(mk("ret_nores2", 1, 0, 0, 0, 0, -1,
                      0, 0, 32'h310, 3, 3, 0, 0));
    for (int i = 0; i < FRAMES; i++)
      vecs.push_back(mk("call_deep", 0, 0, 1, 0, 32'h1000 + i, -1,
                        0, 0, 0, 3, 4 + i, 3 + i, i + 1));
    vecs.push_back(mk("call_frames_full", 0, 0, 1, 0, 32'h2000, -1,
                      1, 1, 0, 1, 19, 18, 16));
    vecs.push_back(mk("ret_deep", 1, 0, 0, 0, 0, -1,
                      0, 0, 32'h100F, 3, 18, 17, 15));
    v = mk("call_staterr", 0, 0, 0, 0, 32'h3000, -1,
           1, 5, 0, 3, 18, 18, 16);
    v.frc = 1'b1;
    vecs.push_back(v);
    vecs.push_back(mk("ret_after_err", 1, 0, 0, 0, 0, -1,
                      0, 0, 32'h3000, 3, 18, 17, 15));

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // CALL over pre-dirtied slots, then carry a result back
    h_do(2'd1, 32'd3);
    repeat (4) h_do(2'd2, 32'hEE);
    h_do(2'd1, 32'd3);
    v = mk("call1", 0, 2, 4, 0, 32'h100, -1, 0, 0, 0, 3, 7, 1, 1);
    v.probe = 1;
    v.p_op  = OP_INDEX_RESET;
    v.p_off = AW'(7);
    v.p_lim = AW'(1);
    run_cmd(v);
    for (int i = 3; i < 7; i++) chk("call1.zero_fill", mem[i], 32'd0);
    h_do(2'd2, 32'hAB);
    v = mk("ret1", 1, 0, 0, 1, 0, -1, 0, 0, 32'h100, 4, 2, 0, 0);
    v.probe  = 2;
    v.p_op   = OP_INDEX_RESET_AND_PUSH;
    v.p_off  = AW'(1);
    v.p_data = 32'hAB;
    v.p_lim  = AW'(0);
    run_cmd(v);
    chk("ret1.result_word", mem[1], 32'hAB);

    for (int k = 0; k < vecs.size(); k++) run_cmd(vecs[k]);

    // reset in the ISSUE cycle of a CALL
    @(posedge clk); #1;
    cif.cmd_valid    = 1'b1;
    cif.cmd_ret      = 1'b0;
    cif.cmd_args     = '0;
    cif.cmd_locals   = AW'(1);
    cif.cmd_ret_addr = 32'h5000;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    chk("mid_reset.issued", 32'(stk_op), 32'(OP_INDEX_RESET));
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset.ready_after", 32'(cif.cmd_ready), 32'd1);
    chk("mid_reset.stack_kept", 32'(stk_index), 32'd18);
    run_cmd(mk("call_post_reset", 0, 0, 0, 0, 32'h4000, -1,
               0, 0, 0, 3, 18, 18, 1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
